// File: rtl/mandelbrot_pkg.sv
// Shared types and colour mapping for the Mandelbrot line streaming path.
package mandelbrot_pkg;

    localparam int unsigned PIXEL_W = 24;

    typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_t;
    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               user;
        logic               last;
    } beat_t;

    // Points that never escaped are drawn black; everything else gets a cheap gradient.
    function automatic logic [PIXEL_W-1:0] depth_to_rgb(input logic [31:0] depth,
                                                        input logic [31:0] max_iter);
        if (depth >= max_iter) return '0;
        return {depth[7:0], depth[6:0], 1'b0, ~depth[7:0]};
    endfunction

endpackage

// File: rtl/line_stream_out_if.sv
// AXI4-Stream video pixel channel towards the display path.
interface line_stream_out_if;
    import mandelbrot_pkg::*;

    logic [PIXEL_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tuser;
    logic               tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/line_stream_out_ram.sv
// Ping-pong line buffer: simple dual-port RAM, bank select is the address MSB.
module line_ram #(
    parameter int unsigned SCREEN_WIDTH = 640,
    parameter int unsigned DEPTH_W      = 10
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic                            wr_bank,
    input  logic [$clog2(SCREEN_WIDTH)-1:0] waddr,
    input  logic [DEPTH_W-1:0]              wdata,
    input  logic                            re,
    input  logic                            rd_bank,
    input  logic [$clog2(SCREEN_WIDTH)-1:0] raddr,
    output logic [DEPTH_W-1:0]              rdata
);
    localparam int unsigned AW = $clog2(SCREEN_WIDTH);

    logic [DEPTH_W-1:0] mem [2**(AW+1)];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, waddr}] <= wdata;
        if (re) rdata <= mem[{rd_bank, raddr}];
    end

endmodule

// File: rtl/line_stream_out.sv
// Captures engine lines into ping-pong RAM banks and streams them as colour-mapped video.
module line_stream_out
    import mandelbrot_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned MAX_ITER      = 200,
    parameter int unsigned DEPTH_W       = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DEPTH_W-1:0]              depth_in,
    input  logic                            we_in,
    input  logic [$clog2(SCREEN_WIDTH)-1:0] addr_in,
    input  logic                            line_done,
    output logic                            engine_start,
    line_stream_out_if.master               m_axis
);
    localparam int unsigned AW = $clog2(SCREEN_WIDTH);
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT);
    localparam logic [AW-1:0] X_LAST = AW'(SCREEN_WIDTH - 1);
    localparam logic [AW:0]   X_END  = (AW+1)'(SCREEN_WIDTH);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

    bank_state_t bank [2];
    bank_state_t bank_nxt [2];

    wr_state_t w_state, w_state_nxt;
    logic      wr_bank, wr_bank_nxt, armed, armed_nxt, start_nxt;
    logic      w_take, w_full, ram_we;

    rd_state_t     r_state, r_state_nxt;
    logic          rd_bank, rd_bank_nxt;
    logic [AW:0]   x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic          r_drain, r_free, issue, push, pop;
    logic          rd_pend;
    logic [AW-1:0] rd_x;
    logic [1:0]    cnt;
    logic [2:0]    occ;
    logic [DEPTH_W-1:0] ram_rdata;
    beat_t         e0, e1, beat_in;

    line_ram #(.SCREEN_WIDTH(SCREEN_WIDTH), .DEPTH_W(DEPTH_W)) u_ram (
        .clk(clk), .we(ram_we), .wr_bank(wr_bank), .waddr(addr_in), .wdata(depth_in),
        .re(issue), .rd_bank(rd_bank), .raddr(x[AW-1:0]), .rdata(ram_rdata)
    );

    // module_done is still high from the previous line when start is pulsed,
    // so a line only completes after line_done has been seen low once (armed).
    always_comb begin
        w_state_nxt = w_state;
        wr_bank_nxt = wr_bank;
        armed_nxt   = armed;
        start_nxt   = 1'b0;
        w_take      = 1'b0;
        w_full      = 1'b0;
        unique case (w_state)
            W_IDLE: if (bank[wr_bank] == FREE) begin
                start_nxt   = 1'b1;
                w_take      = 1'b1;
                armed_nxt   = 1'b0;
                w_state_nxt = W_FILL;
            end
            W_FILL: begin
                if (!line_done) armed_nxt = 1'b1;
                if (line_done && armed) begin
                    w_full      = 1'b1;
                    wr_bank_nxt = ~wr_bank;
                    w_state_nxt = W_IDLE;
                end
            end
        endcase
    end

    assign ram_we = (w_state == W_FILL) && we_in && (addr_in <= X_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state      <= W_IDLE;
            wr_bank      <= 1'b0;
            armed        <= 1'b0;
            engine_start <= 1'b0;
        end else begin
            w_state      <= w_state_nxt;
            wr_bank      <= wr_bank_nxt;
            armed        <= armed_nxt;
            engine_start <= start_nxt;
        end
    end

    assign pop  = (cnt != 2'd0) && m_axis.tready;
    assign push = rd_pend;

    // A read is issued only if its data is guaranteed a slot in the 2-entry buffer
    // when it returns next cycle; this sustains one beat per cycle at tready=1.
    always_comb begin
        r_state_nxt = r_state;
        rd_bank_nxt = rd_bank;
        x_nxt       = x;
        y_nxt       = y;
        r_drain     = 1'b0;
        r_free      = 1'b0;
        issue       = 1'b0;
        occ         = 3'(cnt) + 3'(rd_pend) - 3'(pop);
        unique case (r_state)
            R_IDLE: if (bank[rd_bank] == FULL) begin
                r_drain     = 1'b1;
                issue       = 1'b1;
                x_nxt       = x + (AW+1)'(1);
                r_state_nxt = R_STREAM;
            end
            R_STREAM: begin
                if (x < X_END && occ < 3'd2) begin
                    issue = 1'b1;
                    x_nxt = x + (AW+1)'(1);
                end
                if (pop && e0.last) begin
                    r_free      = 1'b1;
                    rd_bank_nxt = ~rd_bank;
                    y_nxt       = (y == Y_LAST) ? '0 : y + YW'(1);
                    x_nxt       = '0;
                    r_state_nxt = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bank_nxt = bank;
        if (w_take)  bank_nxt[wr_bank] = FILLING;
        if (w_full)  bank_nxt[wr_bank] = FULL;
        if (r_drain) bank_nxt[rd_bank] = DRAINING;
        if (r_free)  bank_nxt[rd_bank] = FREE;
    end

    always_comb begin
        beat_in.data = depth_to_rgb(32'(ram_rdata), 32'(MAX_ITER));
        beat_in.user = (rd_x == '0) && (y == '0);
        beat_in.last = (rd_x == X_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank    <= '{FREE, FREE};
            r_state <= R_IDLE;
            rd_bank <= 1'b0;
            x       <= '0;
            y       <= '0;
            rd_pend <= 1'b0;
            rd_x    <= '0;
            cnt     <= '0;
            e0      <= '0;
            e1      <= '0;
        end else begin
            bank    <= bank_nxt;
            r_state <= r_state_nxt;
            rd_bank <= rd_bank_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            rd_pend <= issue;
            if (issue) rd_x <= x[AW-1:0];
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            case ({push, pop})
                2'b10: if (cnt == 2'd0) e0 <= beat_in; else e1 <= beat_in;
                2'b01: e0 <= e1;
                2'b11: if (cnt == 2'd1) e0 <= beat_in;
                       else begin
                           e0 <= e1;
                           e1 <= beat_in;
                       end
                default: ;
            endcase
        end
    end

    assign m_axis.tvalid = (cnt != 2'd0);
    assign m_axis.tdata  = e0.data;
    assign m_axis.tuser  = e0.user;
    assign m_axis.tlast  = e0.last;

endmodule

// File: tb/tb_line_stream_out.sv
// Randomized scoreboard bench for line_stream_out: engine model feeds lines, monitor checks beats.
module tb_line_stream_out;
    localparam int W    = 640;
    localparam int H    = 480;
    localparam int MAXI = 200;
    localparam int DW   = 10;

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, we_in, line_done, engine_start;
    logic [DW-1:0] depth_in;
    logic [9:0]    addr_in;

    always #5 clk = ~clk;

    line_stream_out_if m_axis_if();

    line_stream_out #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .MAX_ITER(MAXI), .DEPTH_W(DW)) dut (
        .clk(clk), .reset(reset), .depth_in(depth_in), .we_in(we_in), .addr_in(addr_in),
        .line_done(line_done), .engine_start(engine_start), .m_axis(m_axis_if)
    );

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   starts = 0, start_base = 0, beats = 0, ready_mode = 0;
    int   lines_fed = 0, frame_y = 0;
    int   mem_model [2][W];

    function automatic logic [23:0] ref_rgb(input int d);
        if (d >= MAXI) return 24'h000000;
        return {8'(d % 256), 8'((d * 2) % 256), 8'(255 - d % 256)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we_in = 1'b0;
        line_done = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        sb.delete();
        lines_fed = 0;
        frame_y = 0;
        start_base = starts;
    endtask

    task automatic wait_start(input int n);
        for (int i = 0; i < 20000; i++) begin
            if (starts - start_base >= n) return;
            tick();
        end
        chk("start_timeout", longint'(starts - start_base), longint'(n));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && sb.size() != 0; i++) tick();
        chk("drain", longint'(sb.size()), 0);
        repeat (4) tick();
    endtask

    // Engine model: writes one line (optionally skipping a range), then raises
    // module_done; an optional stray write follows while the writer is idle.
    task automatic feed_line(input int kind, input int skip_lo, input int skip_hi, input int garbage);
        int   b, d;
        exp_t e;
        b = lines_fed % 2;
        line_done = 1'b0;
        for (int x = 0; x < W; x++) begin
            if (x >= skip_lo && x <= skip_hi) continue;
            if ($urandom_range(0, 7) == 0) begin
                we_in = 1'b0;
                tick();
            end
            if ($urandom_range(0, 15) == 0) begin
                we_in = 1'b1;
                addr_in = 10'($urandom_range(W, 1023));
                depth_in = DW'($urandom_range(0, 150));
                tick();
            end
            d = (kind == 1) ? x % 201 : int'($urandom_range(0, 260));
            we_in = 1'b1;
            addr_in = 10'(x);
            depth_in = DW'(d);
            mem_model[b][x] = d;
            tick();
        end
        we_in = 1'b0;
        line_done = 1'b1;
        for (int x = 0; x < W; x++) begin
            e.data = ref_rgb(mem_model[b][x]);
            e.user = (frame_y == 0 && x == 0);
            e.last = (x == W - 1);
            sb.push_back(e);
        end
        lines_fed++;
        frame_y = (frame_y + 1) % H;
        tick();
        if (garbage >= 0) begin
            we_in = 1'b1;
            addr_in = 10'(garbage);
            depth_in = (mem_model[b ^ 1][garbage] == 5) ? DW'(6) : DW'(5);
            tick();
            we_in = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t held, got, e;
        logic stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
                continue;
            end
            got = {m_axis_if.tdata, m_axis_if.tuser, m_axis_if.tlast};
            if (engine_start) starts++;
            if (stalled)
                chk("stall_hold", longint'({m_axis_if.tvalid, got}), longint'({1'b1, held}));
            stalled = m_axis_if.tvalid && !m_axis_if.tready;
            held = got;
            if (m_axis_if.tvalid && m_axis_if.tready) begin
                beats++;
                if (sb.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("beat%0d", beats), longint'(got), longint'(e));
                end
            end
        end
    end

    initial begin : ready_drv
        m_axis_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_if.tready = 1'b1;
                1:       m_axis_if.tready = 1'($urandom_range(0, 1));
                default: m_axis_if.tready = 1'b0;
            endcase
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        reset = 1'b1;
        we_in = 1'b0;
        line_done = 1'b1;
        addr_in = '0;
        depth_in = '0;

        // T1: reset values, single start pulse, stale module_done ignored
        do_reset();
        @(negedge clk);
        chk("rst_engine_start", longint'(engine_start), 0);
        chk("rst_tvalid", longint'(m_axis_if.tvalid), 0);
        chk("rst_tdata", longint'(m_axis_if.tdata), 0);
        chk("rst_tuser", longint'(m_axis_if.tuser), 0);
        chk("rst_tlast", longint'(m_axis_if.tlast), 0);
        @(negedge clk);
        chk("start_cycle1", longint'(engine_start), 1);
        @(negedge clk);
        chk("start_one_cycle", longint'(engine_start), 0);
        repeat (30) tick();
        chk("t1_start_count", longint'(starts - start_base), 1);
        chk("t1_no_full", longint'(m_axis_if.tvalid), 0);

        // T2: depth = x % 201, full-rate sink
        ready_mode = 0;
        wait_start(1);
        feed_line(1, -1, -1, -1);
        wait_drain();

        // T3: random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 3; i++) begin
            wait_start(lines_fed + 1);
            feed_line(0, -1, -1, -1);
        end
        wait_drain();

        // T4: sink stalled, both banks fill, engine must stall
        ready_mode = 2;
        wait_start(lines_fed + 1);
        feed_line(0, -1, -1, -1);
        wait_start(lines_fed + 1);
        feed_line(0, -1, -1, -1);
        repeat (60) tick();
        chk("t4_no_third_start", longint'(starts - start_base), longint'(lines_fed));
        chk("t4_pending_beats", longint'(sb.size()), longint'(2 * W));
        ready_mode = 0;
        wait_start(lines_fed + 1);
        chk("t4_start_after_tlast", longint'(sb.size() <= W), 1);
        wait_drain();

        // T5: stray idle write followed by a line with unwritten pixels
        wait_start(lines_fed + 1);
        feed_line(0, -1, -1, 50);
        wait_start(lines_fed + 1);
        feed_line(0, 50, 59, -1);
        wait_drain();

        // T6: reset in the middle of a streamed line
        ready_mode = 1;
        wait_start(lines_fed + 1);
        base = beats;
        feed_line(0, -1, -1, -1);
        for (int i = 0; i < 5000 && beats - base < 300; i++) tick();
        chk("t6_reach_pixel300", longint'(beats - base >= 300), 1);
        do_reset();
        @(negedge clk);
        chk("t6_tvalid_after_reset", longint'(m_axis_if.tvalid), 0);
        ready_mode = 0;
        wait_start(1);
        feed_line(0, -1, -1, -1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
